// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, the latched
// memory operation record and counter width.
package mem_arb_pkg;
   localparam int LAT_W = 4;
   localparam int OP_AW = 16;
   localparam int OP_DW = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BUSY_IF = 3'd1,
      BUSY_D  = 3'd2,
      DONE_IF = 3'd3,
      DONE_D  = 3'd4
   } arb_state_t;

   typedef struct packed {
      logic             wr;
      logic [OP_AW-1:0] addr;
      logic [OP_DW-1:0] wdata;
   } mem_op_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side fetch/data ports and memory-side command bus of the arbiter.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          halt;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic          d_req;
   logic          d_wr;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          mem_en;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          if_stall;
   logic          d_stall;
   logic [15:0]   conflict_cnt;

   modport slave (
      input  halt, if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_done, d_rdata, d_done, mem_en, mem_wr, mem_addr,
             mem_wdata, if_stall, d_stall, conflict_cnt
   );

   modport master (
      output halt, if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_done, d_rdata, d_done, mem_en, mem_wr, mem_addr,
             mem_wdata, if_stall, d_stall, conflict_cnt
   );
endinterface

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter timing the memory latency of the single in-flight op.
module mem_lat_cnt
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [LAT_W-1:0] cnt_r;

   // load has priority; the count parks at zero instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {LAT_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {LAT_W{1'b0}})) begin
         cnt_r <= cnt_r - LAT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {LAT_W{1'b0}});
endmodule

// File: rtl/mem_arbiter.sv
// Single-ported memory sequencer: data port beats fetch, one op in flight,
// per-port done pulses and a saturating count of fetch cycles lost to data.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LAT = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LAT - 1);

   arb_state_t       state_r;
   mem_op_t          op_r;
   logic             mem_en_r;
   logic             if_done_r;
   logic             d_done_r;
   logic [OP_DW-1:0] if_rdata_r;
   logic [OP_DW-1:0] d_rdata_r;
   logic [15:0]      conflict_r;
   logic             fetch_ok_s;
   logic             grant_d_s;
   logic             grant_if_s;
   logic             busy_s;
   logic             cnt_zero_s;

   assign fetch_ok_s = bus.if_req & ~bus.halt;
   assign busy_s     = (state_r == BUSY_IF) || (state_r == BUSY_D);

   // grants happen from IDLE, or straight from DONE to the other port
   always_comb begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.d_req) grant_d_s = 1'b1;
            else if (fetch_ok_s) grant_if_s = 1'b1;
            else grant_if_s = 1'b0;
         end
         DONE_D: begin
            if (fetch_ok_s) grant_if_s = 1'b1;
            else grant_if_s = 1'b0;
         end
         DONE_IF: begin
            if (bus.d_req) grant_d_s = 1'b1;
            else grant_d_s = 1'b0;
         end
         default: begin
            grant_d_s  = 1'b0;
            grant_if_s = 1'b0;
         end
      endcase
   end

   mem_lat_cnt u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (grant_d_s | grant_if_s),
      .load_val (LAT_M1),
      .dec      (busy_s & ~cnt_zero_s),
      .zero     (cnt_zero_s)
   );

   // FSM with registered command, done and capture outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         op_r       <= '{wr: 1'b0, addr: {OP_AW{1'b0}}, wdata: {OP_DW{1'b0}}};
         mem_en_r   <= 1'b0;
         if_done_r  <= 1'b0;
         d_done_r   <= 1'b0;
         if_rdata_r <= {OP_DW{1'b0}};
         d_rdata_r  <= {OP_DW{1'b0}};
         conflict_r <= 16'd0;
      end else begin
         mem_en_r  <= 1'b0;
         if_done_r <= 1'b0;
         d_done_r  <= 1'b0;
         if (grant_d_s) begin
            op_r     <= '{wr: bus.d_wr, addr: bus.d_addr, wdata: bus.d_wdata};
            mem_en_r <= 1'b1;
            state_r  <= BUSY_D;
         end else if (grant_if_s) begin
            op_r     <= '{wr: 1'b0, addr: bus.if_addr, wdata: {OP_DW{1'b0}}};
            mem_en_r <= 1'b1;
            state_r  <= BUSY_IF;
         end else begin
            case (state_r)
               BUSY_IF: begin
                  if (cnt_zero_s) begin
                     if_rdata_r <= bus.mem_rdata;
                     if_done_r  <= 1'b1;
                     state_r    <= DONE_IF;
                  end
               end
               BUSY_D: begin
                  if (cnt_zero_s) begin
                     if (!op_r.wr) d_rdata_r <= bus.mem_rdata;
                     d_done_r <= 1'b1;
                     state_r  <= DONE_D;
                  end
               end
               default: state_r <= IDLE;
            endcase
         end
         if (bus.if_req && !if_done_r && ((state_r == BUSY_D) || (state_r == DONE_D))
             && (conflict_r != 16'hFFFF)) begin
            conflict_r <= conflict_r + 16'd1;
         end
      end
   end

   assign bus.mem_en       = mem_en_r;
   assign bus.mem_wr       = op_r.wr;
   assign bus.mem_addr     = op_r.addr;
   assign bus.mem_wdata    = op_r.wdata;
   assign bus.if_done      = if_done_r;
   assign bus.d_done       = d_done_r;
   assign bus.if_rdata     = if_rdata_r;
   assign bus.d_rdata      = d_rdata_r;
   assign bus.conflict_cnt = conflict_r;
   assign bus.if_stall     = bus.if_req & ~if_done_r;
   assign bus.d_stall      = bus.d_req & ~d_done_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline-based reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
   localparam int LAT = 4;

   logic clk;
   logic rst;
   mem_arbiter_if #(.AW(16), .DW(16)) bus ();
   mem_arbiter_if #(.AW(16), .DW(16)) bus2 ();

   mem_arbiter #(.LAT(LAT)) dut  (.clk(clk), .rst(rst), .bus(bus));
   mem_arbiter #(.LAT(1))   dut1 (.clk(clk), .rst(rst), .bus(bus2));

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // inputs as seen at the coming edge
   logic p_rst, p_halt, p_if_req, p_d_req, p_d_wr;
   logic [15:0] p_if_addr, p_d_addr, p_d_wdata;

   // reference model: one operation on a timeline, memory as a sparse array
   logic        m_active = 1'b0;
   logic        m_port = 1'b0;      // 1 = data port
   int          m_start = 0;        // cycle showing mem_en
   logic        m_wr, m_mem_en, m_if_done, m_d_done;
   logic [15:0] m_addr, m_wdata, m_if_rdata, m_d_rdata, m_conflict;
   logic [15:0] mem [logic [15:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] memval(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      else return a ^ 16'hC3A5;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic done_prev, gd, gf;
      if (p_rst) begin
         m_active = 1'b0; m_wr = 1'b0; m_addr = 16'h0000; m_wdata = 16'h0000;
         m_if_rdata = 16'h0000; m_d_rdata = 16'h0000; m_conflict = 16'h0000;
         m_mem_en = 1'b0; m_if_done = 1'b0; m_d_done = 1'b0;
      end else begin
         done_prev = m_active && ((cyc - 1) == m_start + LAT);
         if (p_if_req && m_active && m_port && m_conflict != 16'hFFFF) m_conflict++;
         gd = p_d_req && !(done_prev && m_port);
         gf = p_if_req && !p_halt && !(done_prev && !m_port);
         if (!m_active || done_prev) begin
            if (gd) begin
               m_active = 1'b1; m_port = 1'b1; m_wr = p_d_wr;
               m_addr = p_d_addr; m_wdata = p_d_wdata; m_start = cyc;
            end else if (gf) begin
               m_active = 1'b1; m_port = 1'b0; m_wr = 1'b0;
               m_addr = p_if_addr; m_start = cyc;
            end else begin
               m_active = 1'b0;
            end
         end
         m_mem_en  = m_active && (m_start == cyc);
         if (m_mem_en && m_wr) mem[m_addr] = m_wdata;
         m_if_done = m_active && !m_port && (cyc == m_start + LAT);
         m_d_done  = m_active && m_port && (cyc == m_start + LAT);
         if (m_if_done) m_if_rdata = memval(m_addr);
         if (m_d_done && !m_wr) m_d_rdata = memval(m_addr);
      end
   endtask

   task automatic tick();
      p_rst = rst; p_halt = bus.halt; p_if_req = bus.if_req; p_if_addr = bus.if_addr;
      p_d_req = bus.d_req; p_d_wr = bus.d_wr; p_d_addr = bus.d_addr; p_d_wdata = bus.d_wdata;
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      if (m_active && !m_wr && (cyc == m_start + LAT - 1)) bus.mem_rdata = memval(m_addr);
      else bus.mem_rdata = 16'($urandom);
      chk_en = 1'b1;
   endtask

   // per-cycle comparison against the model, mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_en", {31'd0, bus.mem_en}, {31'd0, m_mem_en});
         if (m_mem_en) chk("mem_wr", {31'd0, bus.mem_wr}, {31'd0, m_wr});
         chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, m_addr});
         if (m_mem_en && m_wr) chk("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, m_wdata});
         chk("if_done", {31'd0, bus.if_done}, {31'd0, m_if_done});
         chk("d_done", {31'd0, bus.d_done}, {31'd0, m_d_done});
         chk("if_rdata", {16'd0, bus.if_rdata}, {16'd0, m_if_rdata});
         chk("d_rdata", {16'd0, bus.d_rdata}, {16'd0, m_d_rdata});
         chk("conflict_cnt", {16'd0, bus.conflict_cnt}, {16'd0, m_conflict});
         chk("if_stall", {31'd0, bus.if_stall}, {31'd0, bus.if_req & ~m_if_done});
         chk("d_stall", {31'd0, bus.d_stall}, {31'd0, bus.d_req & ~m_d_done});
      end
   end

   initial begin
      int en_cnt, done_at, ifd;
      rst = 1'b1;
      bus.halt = 1'b0; bus.if_req = 1'b0; bus.if_addr = 16'h0000; bus.d_req = 1'b0;
      bus.d_wr = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000; bus.mem_rdata = 16'h0000;
      bus2.halt = 1'b0; bus2.if_req = 1'b0; bus2.if_addr = 16'h0000; bus2.d_req = 1'b0;
      bus2.d_wr = 1'b0; bus2.d_addr = 16'h0000; bus2.d_wdata = 16'h0000; bus2.mem_rdata = 16'h0000;
      mem[16'h0010] = 16'hA1B2;
      mem[16'h2000] = 16'h1357;
      tick();
      rst = 1'b0;
      tick();
      chk("reset_conflict", {16'd0, bus.conflict_cnt}, 32'd0);
      chk("reset_if_rdata", {16'd0, bus.if_rdata}, 32'd0);

      // LAT=1 build: fetch 0x0002, then back-to-back fetch
      bus2.if_req = 1'b1; bus2.if_addr = 16'h0002; bus2.mem_rdata = 16'hBEEF;
      tick();
      chk("lat1_mem_en_c1", {31'd0, bus2.mem_en}, 32'd1);
      chk("lat1_mem_addr", {16'd0, bus2.mem_addr}, 32'h0002);
      tick();
      chk("lat1_if_done_c2", {31'd0, bus2.if_done}, 32'd1);
      chk("lat1_if_rdata", {16'd0, bus2.if_rdata}, 32'hBEEF);
      tick();
      chk("lat1_mem_en_c3", {31'd0, bus2.mem_en}, 32'd0);
      tick();
      chk("lat1_mem_en_c4", {31'd0, bus2.mem_en}, 32'd1);
      bus2.if_req = 1'b0;
      repeat (3) tick();

      // fetch only
      bus.if_req = 1'b1; bus.if_addr = 16'h0010;
      tick();
      chk("t1_mem_en", {31'd0, bus.mem_en}, 32'd1);
      chk("t1_mem_addr", {16'd0, bus.mem_addr}, 32'h0010);
      chk("t1_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      chk("t1_model_mem_en", {31'd0, m_mem_en}, 32'd1);
      repeat (3) tick();
      chk("t1_if_done_c4", {31'd0, bus.if_done}, 32'd0);
      tick();
      chk("t1_if_done_c5", {31'd0, bus.if_done}, 32'd1);
      chk("t1_if_rdata", {16'd0, bus.if_rdata}, 32'hA1B2);
      chk("t1_model_rdata", {16'd0, m_if_rdata}, 32'hA1B2);
      bus.if_req = 1'b0;
      tick();

      // simultaneous requests
      rst = 1'b1; tick(); rst = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 16'h0010;
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h2000;
      tick();
      chk("t2_mem_en_c1", {31'd0, bus.mem_en}, 32'd1);
      chk("t2_mem_addr_c1", {16'd0, bus.mem_addr}, 32'h2000);
      repeat (4) tick();
      chk("t2_d_done_c5", {31'd0, bus.d_done}, 32'd1);
      chk("t2_d_rdata", {16'd0, bus.d_rdata}, 32'h1357);
      bus.d_req = 1'b0;
      tick();
      chk("t2_mem_en_c6", {31'd0, bus.mem_en}, 32'd1);
      chk("t2_mem_addr_c6", {16'd0, bus.mem_addr}, 32'h0010);
      repeat (4) tick();
      chk("t2_if_done_c10", {31'd0, bus.if_done}, 32'd1);
      chk("t2_conflict", {16'd0, bus.conflict_cnt}, 32'd5);
      chk("t2_model_conflict", {16'd0, m_conflict}, 32'd5);
      bus.if_req = 1'b0;
      tick();

      // store
      bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h3000; bus.d_wdata = 16'h5A5A;
      tick();
      chk("t3_mem_en", {31'd0, bus.mem_en}, 32'd1);
      chk("t3_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
      chk("t3_mem_addr", {16'd0, bus.mem_addr}, 32'h3000);
      chk("t3_mem_wdata", {16'd0, bus.mem_wdata}, 32'h5A5A);
      repeat (4) tick();
      chk("t3_d_done_c5", {31'd0, bus.d_done}, 32'd1);
      chk("t3_d_rdata_kept", {16'd0, bus.d_rdata}, 32'h1357);
      bus.d_req = 1'b0; bus.d_wr = 1'b0;
      tick();

      // halt blocks fetch; data still served
      bus.halt = 1'b1; bus.if_req = 1'b1; bus.if_addr = 16'h0040;
      en_cnt = 0; done_at = 0; ifd = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 8) begin bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h2000; end
         tick();
         if (bus.mem_en) en_cnt++;
         if (bus.if_done) ifd++;
         if (bus.d_done) begin done_at = i; bus.d_req = 1'b0; end
      end
      chk("t4_mem_en_count", en_cnt, 32'd1);
      chk("t4_d_done_cycle", done_at, 32'd12);
      chk("t4_no_if_done", ifd, 32'd0);
      bus.if_req = 1'b0; bus.halt = 1'b0;
      tick();

      // reset during a fetch
      bus.if_req = 1'b1; bus.if_addr = 16'h0050;
      tick();
      chk("t5_mem_en_c1", {31'd0, bus.mem_en}, 32'd1);
      tick();
      rst = 1'b1; bus.if_req = 1'b0;
      tick();
      rst = 1'b0;
      chk("t5_mem_en_c3", {31'd0, bus.mem_en}, 32'd0);
      chk("t5_mem_addr_c3", {16'd0, bus.mem_addr}, 32'd0);
      chk("t5_if_rdata_c3", {16'd0, bus.if_rdata}, 32'd0);
      chk("t5_d_rdata_c3", {16'd0, bus.d_rdata}, 32'd0);
      ifd = 0;
      repeat (8) begin tick(); if (bus.if_done) ifd++; end
      chk("t5_no_if_done", ifd, 32'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) bus.halt = ~bus.halt;
         if (!bus.if_req) begin
            if ($urandom_range(0, 3) == 0) begin
               bus.if_req = 1'b1; bus.if_addr = 16'($urandom_range(0, 15));
            end
         end else if (m_if_done) begin
            if ($urandom_range(0, 1) == 1) bus.if_addr = 16'($urandom_range(0, 15));
            else bus.if_req = 1'b0;
         end
         if (!bus.d_req) begin
            if ($urandom_range(0, 3) == 0) begin
               bus.d_req = 1'b1; bus.d_wr = 1'($urandom_range(0, 1));
               bus.d_addr = 16'($urandom_range(0, 15)); bus.d_wdata = 16'($urandom);
            end
         end else if (m_d_done) begin
            if ($urandom_range(0, 1) == 1) begin
               bus.d_wr = 1'($urandom_range(0, 1));
               bus.d_addr = 16'($urandom_range(0, 15)); bus.d_wdata = 16'($urandom);
            end else begin
               bus.d_req = 1'b0;
            end
         end
      end
      rst = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
      repeat (10) tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single-ported, fixed-latency unified memory between the CPU's instruction-fetch port and its data port (LW/SW). It sits between the CPU datapath and the memory model. It holds at most one memory operation in flight and gives data accesses priority over fetch. It produces per-port done pulses that the CPU uses to release its stalls, and it blocks new fetches once the control path asserts halt.

## Interface
- LAT, 4, memory latency in cycles, counting the mem_en cycle as cycle 1; legal range 1..15
- AW, 16, address width
- DW, 16, data width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- halt  in  1  HLT decoded; blocks new fetch grants
- if_req  in  1  fetch request; held until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word, valid in the if_done cycle
- if_done  out  1  one-cycle completion pulse
- d_req  in  1  data request; held until d_done
- d_wr  in  1  1 means store (SW), 0 means load (LW)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid in the d_done cycle
- d_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory command strobe, one cycle per operation
- mem_wr  out  1  write enable, qualified by mem_en
- mem_addr  out  AW  command address
- mem_wdata  out  DW  command write data
- mem_rdata  in  DW  read data, valid on cycle LAT of an operation
- if_stall  out  1  if_req & ~if_done
- d_stall  out  1  d_req & ~d_done
- conflict_cnt  out  16  saturating count of fetch cycles lost to data

## Operation
- States: IDLE, BUSY_IF, BUSY_D, DONE_IF, DONE_D.
- Eligibility: a fetch is eligible when if_req & ~halt. Data is eligible when d_req.
- Grant decision in IDLE: data wins over fetch. The granted op's address, write data and write enable are latched, the counter is loaded with LAT-1, and the FSM moves to BUSY_D or BUSY_IF.
- BUSY_x:
  - mem_en=1 only in the first BUSY cycle.
  - The counter decrements each cycle.
  - When the counter reaches 0, mem_rdata is captured (reads only) and the FSM moves to DONE_x.
- DONE_x: x_done=1. In this cycle x_req is treated as stale and ignored.
  - If the other port is eligible, grant it directly (no IDLE bubble).
  - Otherwise go to IDLE.
- A same-port back-to-back request is sampled in IDLE, the cycle after DONE.
- Stores: mem_wr=1 with mem_en. d_done pulses after LAT cycles like a load. d_rdata holds its previous value.
- if_rdata and d_rdata are registers and hold their value until the next capture for that port.
- halt does not abort an in-flight fetch; that fetch completes normally. Data requests are always served.
- conflict_cnt: +1 per cycle with if_req high, if_done low, and state BUSY_D or DONE_D. Saturates at 0xFFFF.
- rst:
  - State goes to IDLE; counter, conflict_cnt, if_rdata and d_rdata go to 0.
  - Any in-flight operation is abandoned and no done pulse follows. A write already issued to memory may complete there.

## Timing
- Reset values: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, conflict_cnt=0.
- if_stall and d_stall are combinational and follow the request inputs even during reset.
- Cycle numbering: a request is first sampled at edge E0.
  - Cycle 1: mem_en.
  - Cycle LAT: memory data valid.
  - Cycle LAT+1: done pulse.
- Latency from request to done is LAT+1 cycles. A port switch adds no idle cycle.
- mem_* command outputs are registered and stay stable for the whole BUSY period.
- Requesters must hold req, addr, wr and wdata stable until done; behaviour otherwise is undefined.

## Structure
- Package mem_arb_pkg holds:
  - the state enum arb_state_t;
  - LAT_W=4;
  - the op record type {wr, addr, wdata}.
- Sub-module mem_lat_cnt: loadable down-counter with a zero flag, shared by both ports.
- The top level holds the FSM, the grant logic, the capture registers and conflict_cnt.

## Test plan
- Fetch only, LAT=4: if_req addr=0x0010, memory returns 0xA1B2 in cycle 4 → mem_en cycle 1 with mem_addr=0x0010 and mem_wr=0; if_done cycle 5 with if_rdata=0xA1B2.
- Simultaneous requests: if_req at 0x0010 and LW d_req at 0x2000 → data mem_en cycle 1, d_done cycle 5; fetch mem_en cycle 6, if_done cycle 10; conflict_cnt=5.
- SW: d_wr=1, d_addr=0x3000, d_wdata=0x5A5A → cycle 1 shows mem_en=1, mem_wr=1, 0x3000/0x5A5A; d_done cycle 5; d_rdata unchanged.
- halt high with if_req held for 20 cycles → no mem_en. A d_req issued mid-window is still served (d_done after 5 cycles).
- rst asserted in cycle 2 of a fetch → from cycle 3 the state is IDLE and mem_en=0; no if_done; all outputs at reset values.
- LAT=1 build, fetch 0x0002 → mem_en cycle 1, if_done cycle 2. Back-to-back fetches have mem_en 3 cycles apart.
